// File: rtl/pipeline_stage4_mem_if.sv
// Data-memory request/response bus between the MEM stage (master) and the data memory (slave).
// A request is accepted in the cycle with req=1 and ready=1; load data returns later with rvalid.
interface pipeline_stage4_mem_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        ready;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (output req, we, addr, wdata, be, input ready, rvalid, rdata);
    modport slave  (input req, we, addr, wdata, be, output ready, rvalid, rdata);
endinterface

// File: rtl/pipeline_stage4_mem.sv
// MEM stage of the 5-stage RISC-V pipeline: issues loads/stores on the data-memory bus,
// stalls upstream while a transaction is outstanding and registers the MEM/WB bundle.
module pipeline_stage4_mem (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         RegWrite,
    input  logic                         MemWrite,
    input  logic [1:0]                   Result,
    input  logic [4:0]                   RdD,
    input  logic [31:0]                  ALU_Result,
    input  logic [31:0]                  wdata,
    input  logic [31:0]                  pc_incr4,
    input  logic [1:0]                   access_type,
    input  logic                         u,
    pipeline_stage4_mem_if.master        dmem,
    output logic                         stall_o,
    output logic                         misalign_o,
    output logic                         RegWrite_o,
    output logic [1:0]                   Result_o,
    output logic [4:0]                   RdD_o,
    output logic [31:0]                  ALU_Result_o,
    output logic [31:0]                  ReadData_o,
    output logic [31:0]                  pc_incr4_o
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_ACK  = 2'd1,
        WAIT_DATA = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        regwrite_q, regwrite_d;
    logic [1:0]  result_q, result_d;
    logic [4:0]  rdd_q, rdd_d;
    logic [31:0] alu_q, alu_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] pc_q, pc_d;
    logic        misalign_q, misalign_d;

    logic        is_store_s, is_load_s, mem_op_s, misalign_s;
    logic        req_s, stall_s, complete_s, bubble_s;
    logic [1:0]  off_s;
    logic [3:0]  be_s;
    logic [31:0] wdata_rep_s;

    // Extract the addressed byte/half from the response word and extend it to 32 bits.
    function automatic logic [31:0] format_load(input logic [31:0] rdata,
                                                input logic [1:0]  off,
                                                input logic [1:0]  size,
                                                input logic        uns);
        logic [31:0] sh;
        sh = rdata >> {off, 3'b000};
        case (size)
            2'b00:   format_load = {{24{~uns & sh[7]}},  sh[7:0]};
            2'b01:   format_load = {{16{~uns & sh[15]}}, sh[15:0]};
            default: format_load = rdata;
        endcase
    endfunction

    assign is_store_s = MemWrite;
    assign is_load_s  = ~MemWrite & (Result == 2'b01);
    assign mem_op_s   = is_store_s | is_load_s;
    assign off_s      = ALU_Result[1:0];

    // Alignment check, byte enables and lane-replicated store data by access size.
    always_comb begin
        misalign_s  = 1'b0;
        be_s        = 4'b1111;
        wdata_rep_s = wdata;
        case (access_type)
            2'b00: begin
                misalign_s  = 1'b0;
                be_s        = 4'b0001 << off_s;
                wdata_rep_s = {4{wdata[7:0]}};
            end
            2'b01: begin
                misalign_s  = off_s[0];
                be_s        = 4'b0011 << off_s;
                wdata_rep_s = {2{wdata[15:0]}};
            end
            default: begin
                misalign_s  = (off_s != 2'b00);
                be_s        = 4'b1111;
                wdata_rep_s = wdata;
            end
        endcase
    end

    // Access FSM decode: request, stall, completion and next state.
    always_comb begin
        state_d    = state_q;
        req_s      = 1'b0;
        stall_s    = 1'b0;
        complete_s = 1'b0;
        bubble_s   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!mem_op_s) begin
                    complete_s = 1'b1;
                end else if (misalign_s) begin
                    complete_s = 1'b1;
                    bubble_s   = 1'b1;
                end else begin
                    req_s = 1'b1;
                    if (dmem.ready) begin
                        if (is_store_s) begin
                            complete_s = 1'b1;
                        end else begin
                            stall_s = 1'b1;
                            state_d = WAIT_DATA;
                        end
                    end else begin
                        stall_s = 1'b1;
                        state_d = WAIT_ACK;
                    end
                end
            end
            WAIT_ACK: begin
                req_s = 1'b1;
                if (dmem.ready) begin
                    if (is_store_s) begin
                        complete_s = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        stall_s = 1'b1;
                        state_d = WAIT_DATA;
                    end
                end else begin
                    stall_s = 1'b1;
                end
            end
            WAIT_DATA: begin
                if (dmem.rvalid) begin
                    complete_s = 1'b1;
                    state_d    = IDLE;
                end else begin
                    stall_s = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // MEM/WB next value: the instruction on completion, otherwise a bubble.
    always_comb begin
        misalign_d = bubble_s;
        if (complete_s && !bubble_s) begin
            regwrite_d = RegWrite;
            result_d   = Result;
            rdd_d      = RdD;
            alu_d      = ALU_Result;
            rdata_d    = is_load_s ? format_load(dmem.rdata, off_s, access_type, u) : 32'd0;
            pc_d       = pc_incr4;
        end else begin
            regwrite_d = 1'b0;
            result_d   = 2'b00;
            rdd_d      = 5'd0;
            alu_d      = 32'd0;
            rdata_d    = 32'd0;
            pc_d       = 32'd0;
        end
    end

    // State and MEM/WB register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            regwrite_q <= 1'b0;
            result_q   <= 2'b00;
            rdd_q      <= 5'd0;
            alu_q      <= 32'd0;
            rdata_q    <= 32'd0;
            pc_q       <= 32'd0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            regwrite_q <= regwrite_d;
            result_q   <= result_d;
            rdd_q      <= rdd_d;
            alu_q      <= alu_d;
            rdata_q    <= rdata_d;
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
        end
    end

    // Request and stall are gated by rst so an in-flight access is dropped immediately.
    assign dmem.req   = req_s & ~rst;
    assign dmem.we    = MemWrite;
    assign dmem.addr  = {ALU_Result[31:2], 2'b00};
    assign dmem.be    = be_s;
    assign dmem.wdata = wdata_rep_s;
    assign stall_o    = stall_s & ~rst;

    assign misalign_o   = misalign_q;
    assign RegWrite_o   = regwrite_q;
    assign Result_o     = result_q;
    assign RdD_o        = rdd_q;
    assign ALU_Result_o = alu_q;
    assign ReadData_o   = rdata_q;
    assign pc_incr4_o   = pc_q;

endmodule

// File: doc/pipeline_stage4_mem.md
# pipeline_stage4_mem

Memory-access stage of the 5-stage RISC-V pipeline: consumes the EX/MEM register outputs of the execute stage, drives a request/ready/rvalid data-memory port for loads and stores (byte/half/word, signed/unsigned), and registers the MEM/WB bundle for write-back. It owns a small access FSM and raises `stall_o` to freeze IF–EX while a memory transaction is outstanding.

## Interface
- No parameters.
- `clk  in  1`: single clock, rising edge.
- `rst  in  1`: asynchronous, active-high reset.
- `RegWrite  in  1`: EX/MEM register-write enable.
- `MemWrite  in  1`: store.
- `Result  in  2`: write-back select. 00 ALU, 01 load data, 10 pc+4. 01 marks a load.
- `RdD  in  5`: destination register.
- `ALU_Result  in  32`: effective address, or ALU value.
- `wdata  in  32`: store data; the low byte/half is significant.
- `pc_incr4  in  32`: PC+4.
- `type  in  2`: access size. 00 byte, 01 half, 10 word, 11 treated as word.
- `u  in  1`: load is unsigned (zero-extend).
- `dmem_req  out  1`, `dmem_we  out  1`, `dmem_addr  out  32`, `dmem_wdata  out  32`, `dmem_be  out  4`: memory request bus.
- `dmem_ready  in  1`: request accepted this cycle.
- `dmem_rvalid  in  1`, `dmem_rdata  in  32`: load response.
- `stall_o  out  1`: combinational; hold all upstream stages and the EX/MEM register.
- `misalign_o  out  1`: registered one-cycle pulse on a misaligned access.
- `RegWrite_o  out  1`, `Result_o  out  2`, `RdD_o  out  5`, `ALU_Result_o  out  32`, `ReadData_o  out  32`, `pc_incr4_o  out  32`: MEM/WB register.

## Operation
- **Access qualification.** mem_op = MemWrite | (Result==01).
  - Misaligned: half with addr[0]=1, or word with addr[1:0]≠00.
- **Request fields.**
  - `dmem_addr` = {ALU_Result[31:2],2'b00}.
  - `dmem_we` = MemWrite.
  - `dmem_be`:
    - byte: 0001<<addr[1:0]
    - half: 0011<<addr[1:0]
    - word: 1111
  - `dmem_wdata`:
    - byte: {4{wdata[7:0]}}
    - half: {2{wdata[15:0]}}
    - word: wdata
- **Load formatting.**
  - Take dmem_rdata >> (8·addr[1:0]) and keep the low byte or half.
  - Sign-extend when u=0, zero-extend when u=1. Word loads pass through.
  - The address offset, size and u come from the held inputs.
- **FSM states:** IDLE, WAIT_ACK, WAIT_DATA.
  - **IDLE, non-mem op:** the instruction completes this cycle.
  - **IDLE, aligned mem op:** dmem_req=1.
    - Store with dmem_ready: completes this cycle.
    - Load with dmem_ready: go to WAIT_DATA.
    - No dmem_ready: go to WAIT_ACK.
  - **IDLE, misaligned mem op:** no request. The instruction completes as a bubble (RegWrite_o=0) and misalign_o=1 next cycle.
  - **WAIT_ACK:** dmem_req=1 with identical fields.
    - On dmem_ready, a store completes and the FSM returns to IDLE.
    - On dmem_ready, a load goes to WAIT_DATA.
  - **WAIT_DATA:** dmem_req=0. On dmem_rvalid the load completes and the FSM returns to IDLE.
    - dmem_rvalid outside WAIT_DATA is ignored.
- **stall_o** is 1 whenever a mem op is present and not completing this cycle:
  - a load in IDLE;
  - WAIT_ACK, except a store accepted that cycle;
  - WAIT_DATA without rvalid.
- **MEM/WB register update.**
  - On the completion edge it loads the inputs. ReadData_o gets the formatted load data for loads and 0 otherwise.
  - On any stalled edge it loads a bubble: RegWrite_o=0, Result_o=00, RdD_o=0. The other fields are don't-care but driven 0.
- **Upstream duty:** inputs stay stable while stall_o=1.

## Timing
- **Reset:**
  - All registered outputs are 0, including misalign_o, and the state is IDLE.
  - dmem_req drops immediately on rst assertion because it is gated by rst.
  - An in-flight transaction is abandoned; a later dmem_rvalid is ignored in IDLE.
- **Latency:**
  - Non-mem op and accepted store: 1 cycle. MEM/WB is updated on the next edge.
  - Store waiting n cycles for ready: n+1 cycles.
  - Load: ready in cycle a, rvalid in cycle r>a. MEM/WB is updated at the end of cycle r, and stall_o=1 in cycles 0..r−1.
- **Response ordering:** rvalid in the same cycle as ready is not legal. The earliest rvalid is the cycle after acceptance.
- **Throughput:** back-to-back accepted stores complete one per cycle. Loads take at least 2 cycles.

## Test plan
- **Reset pulse mid-load.** Load issued, ready=1, rst raised in WAIT_DATA.
  - dmem_req=0 at once, all outputs 0, state IDLE.
  - An rvalid after release is ignored and stall_o=0.
- **ADD passthrough.** Result=00, RdD=5, ALU_Result=0x1234.
  - Next edge: RegWrite_o=1, RdD_o=5, ALU_Result_o=0x1234, ReadData_o=0.
  - No dmem_req, stall_o never asserted.
- **SB with backpressure.** SB, addr 0x1003, wdata 0xAB, ready low 2 cycles.
  - dmem_req held 3 cycles with be=1000, wdata=0xABABABAB, addr=0x1000.
  - stall_o high for the 2 waiting cycles.
- **LB signed vs LBU.** Addr 0x2002, rdata 0x00F50000, rvalid 3 cycles after accept.
  - LB: ReadData_o=0xFFFFFFF5. LBU: ReadData_o=0x000000F5.
  - stall_o high until the rvalid cycle, and bubbles are written meanwhile.
- **Misaligned LW.** LW at 0x3002.
  - No dmem_req, misalign_o=1 for exactly one cycle, RegWrite_o=0.
- **Unsigned halfword.** LHU at 0x4002, rdata 0x8001xxxx → ReadData_o=0x00008001.
  - Then an LW at 0x4004 issued on the following cycle is accepted back-to-back.
